sram_arbiter: RTL and testbench

Two-port arbiter that shares the single data SRAM between the microprocessor (requester 0) and an external loader/debug port (requester 1). It sequences accesses with a registered owner state machine, round-robin fairness and a bounded burst length. It returns read data with a valid strobe one cycle after each read access. It sits between the processor's SRAM port and the SRAM macro.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin pick used by the SRAM arbiter.
package sram_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

   // Returns the requester index to own the SRAM; on contention the one that did not own it last wins.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last_owner);
      logic w_pick;
      if (req0 && !req1)
         w_pick = 1'b0;
      else if (req1 && !req0)
         w_pick = 1'b1;
      else
         w_pick = ~last_owner;
      return w_pick;
   endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the CPU (requester 0) and a loader/debug port (requester 1).
// Grant one cycle after IDLE, zero-bubble handover, read valid one cycle after the granted read.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N         = 8,
   parameter int ADDR_W    = 8,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [N-1:0]      wdata0,
   input  logic [N-1:0]      wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [N-1:0]      rdata0,
   output logic [N-1:0]      rdata1,
   output logic              SRAM_readEnable,
   output logic              SRAM_writeEnable,
   output logic [ADDR_W-1:0] SRAM_address,
   output logic [N-1:0]      SRAM_data_in,
   input  logic [N-1:0]      SRAM_data
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

   arb_state_t       r_state;
   logic             r_last_owner;
   logic [CNT_W-1:0] r_burst_cnt;
   logic [1:0]       r_rvalid;

   arb_state_t       w_state_nxt;
   logic             w_last_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_own;
   logic             w_owning;
   logic             w_req_own;
   logic             w_req_oth;
   logic             w_we_own;

   // Note: the reset port is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state      <= IDLE;
         r_last_owner <= 1'b1;
         r_burst_cnt  <= '0;
         r_rvalid     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_nxt;
         r_burst_cnt  <= w_cnt_nxt;
         r_rvalid     <= {gnt1 & req1 & ~we1, gnt0 & req0 & ~we0};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last_owner;
      w_cnt_nxt   = r_burst_cnt;
      w_owning    = (r_state == OWN0) || (r_state == OWN1);
      w_own       = (r_state == OWN1);
      w_req_own   = w_own ? req1 : req0;
      w_req_oth   = w_own ? req0 : req1;
      w_we_own    = w_own ? we1 : we0;

      case (r_state)
         IDLE: begin
            if (req0 || req1)
               w_state_nxt = rr_pick(req0, req1, r_last_owner) ? OWN1 : OWN0;
         end
         OWN0, OWN1: begin
            if (!w_req_own) begin
               w_state_nxt = w_req_oth ? (w_own ? OWN0 : OWN1) : IDLE;
               w_cnt_nxt   = '0;
               w_last_nxt  = w_own;
            end else if (r_burst_cnt == CNT_LAST) begin
               // Burst limit reached: hand over only if the other side is waiting.
               w_cnt_nxt = '0;
               if (w_req_oth) begin
                  w_state_nxt = w_own ? OWN0 : OWN1;
                  w_last_nxt  = w_own;
               end
            end else begin
               w_cnt_nxt = r_burst_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign gnt0             = (r_state == OWN0) & req0;
   assign gnt1             = (r_state == OWN1) & req1;
   assign SRAM_readEnable  = w_owning & w_req_own & ~w_we_own;
   assign SRAM_writeEnable = w_owning & w_req_own & w_we_own;
   assign SRAM_address     = (r_state == OWN0) ? addr0  : (r_state == OWN1) ? addr1  : '0;
   assign SRAM_data_in     = (r_state == OWN0) ? wdata0 : (r_state == OWN1) ? wdata1 : '0;

   assign rvalid0 = r_rvalid[0];
   assign rvalid1 = r_rvalid[1];
   assign rdata0  = SRAM_data;
   assign rdata1  = SRAM_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance a uses BURST_MAX=4, instance b uses BURST_MAX=1.
module tb_sram_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, sram_data = '0;

   logic       a_gnt0, a_gnt1, a_rv0, a_rv1, a_re, a_we;
   logic [7:0] a_rd0, a_rd1, a_addr, a_din;
   logic       b_gnt0, b_gnt1, b_rv0, b_rv1, b_re, b_we;
   logic [7:0] b_rd0, b_rd1, b_addr, b_din;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.N(8), .ADDR_W(8), .BURST_MAX(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rv0), .rvalid1(a_rv1),
      .rdata0(a_rd0), .rdata1(a_rd1), .SRAM_readEnable(a_re), .SRAM_writeEnable(a_we),
      .SRAM_address(a_addr), .SRAM_data_in(a_din), .SRAM_data(sram_data));

   sram_arbiter #(.N(8), .ADDR_W(8), .BURST_MAX(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rv0), .rvalid1(b_rv1),
      .rdata0(b_rd0), .rdata1(b_rd1), .SRAM_readEnable(b_re), .SRAM_writeEnable(b_we),
      .SRAM_address(b_addr), .SRAM_data_in(b_din), .SRAM_data(sram_data));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      rst_n = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      n_total++;
      if ({a_gnt0, a_gnt1, a_rv0, a_rv1, a_re, a_we} !== 6'b0)
         $display("FAIL reset_flags: got %b expected 000000", {a_gnt0, a_gnt1, a_rv0, a_rv1, a_re, a_we});
      else n_pass++;
      n_total++;
      if ({a_addr, a_din} !== 16'h0000)
         $display("FAIL reset_sram_bus: got %h expected 0000", {a_addr, a_din});
      else n_pass++;
   endtask

   task automatic test_read;
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
      #1;
      n_total++;
      if (a_gnt0 !== 1'b0) $display("FAIL read_idle_nogrant: got %b expected 0", a_gnt0);
      else n_pass++;
      step();
      n_total++;
      if ({a_gnt0, a_re, a_we, a_addr} !== {1'b1, 1'b1, 1'b0, 8'h10})
         $display("FAIL read_grant: got %b%b%b/%h expected 110/10", a_gnt0, a_re, a_we, a_addr);
      else n_pass++;
      step();
      req0 = 1'b0; sram_data = 8'hA5;
      #1;
      n_total++;
      if ({a_rv0, a_rd0} !== {1'b1, 8'hA5})
         $display("FAIL read_data: got %b/%h expected 1/a5", a_rv0, a_rd0);
      else n_pass++;
      n_total++;
      if (a_rv1 !== 1'b0) $display("FAIL read_rvalid1: got %b expected 0", a_rv1);
      else n_pass++;
      step();
      n_total++;
      if (a_rv0 !== 1'b0) $display("FAIL read_rvalid_once: got %b expected 0", a_rv0);
      else n_pass++;
   endtask

   task automatic test_burst;
      logic [2:0] exp_f;
      logic [7:0] exp_a;
      int owner;
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h22;
      #1;
      n_total++;
      if ({a_gnt0, a_gnt1, a_we} !== 3'b000)
         $display("FAIL burst_first: got %b expected 000", {a_gnt0, a_gnt1, a_we});
      else n_pass++;
      for (int k = 1; k <= 16; k++) begin
         step();
         owner = ((k - 1) / 4) % 2;
         exp_f = {owner == 0, owner == 1, 1'b1};
         exp_a = (owner == 0) ? 8'h20 : 8'h30;
         n_total++;
         if ({a_gnt0, a_gnt1, a_we, a_addr} !== {exp_f, exp_a})
            $display("FAIL burst_cycle%0d: got %b/%h expected %b/%h", k, {a_gnt0, a_gnt1, a_we}, a_addr, exp_f, exp_a);
         else n_pass++;
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_alternate;
      logic [3:0] exp_v;
      logic g0, pg0;
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h50;
      pg0 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         g0 = (k % 2) == 1;
         exp_v = (k == 1) ? {g0, ~g0, 2'b00} : {g0, ~g0, pg0, ~pg0};
         n_total++;
         if ({b_gnt0, b_gnt1, b_rv0, b_rv1} !== exp_v)
            $display("FAIL alt_cycle%0d: got %b expected %b", k, {b_gnt0, b_gnt1, b_rv0, b_rv1}, exp_v);
         else n_pass++;
         pg0 = g0;
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_midburst;
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h60;
      step();
      step();
      step();
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h70;
      #1;
      n_total++;
      if ({a_gnt0, a_gnt1} !== 2'b10) $display("FAIL mid_c3: got %b expected 10", {a_gnt0, a_gnt1});
      else n_pass++;
      step();
      n_total++;
      if ({a_gnt0, a_gnt1} !== 2'b10) $display("FAIL mid_c4: got %b expected 10", {a_gnt0, a_gnt1});
      else n_pass++;
      step();
      n_total++;
      if ({a_gnt0, a_gnt1, a_we, a_addr} !== {3'b011, 8'h70})
         $display("FAIL mid_handover: got %b/%h expected 011/70", {a_gnt0, a_gnt1, a_we}, a_addr);
      else n_pass++;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_release;
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h80;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_total++;
         if ({a_gnt1, a_we} !== 2'b11) $display("FAIL rel_write%0d: got %b expected 11", k, {a_gnt1, a_we});
         else n_pass++;
      end
      step();
      req1 = 1'b0;
      #1;
      n_total++;
      if ({a_gnt1, a_we} !== 2'b00) $display("FAIL rel_drop: got %b expected 00", {a_gnt1, a_we});
      else n_pass++;
      step();
      req0 = 1'b1; we0 = 1'b1; req1 = 1'b1;
      #1;
      n_total++;
      if ({a_gnt0, a_gnt1} !== 2'b00) $display("FAIL rel_idle: got %b expected 00", {a_gnt0, a_gnt1});
      else n_pass++;
      step();
      n_total++;
      if ({a_gnt0, a_gnt1} !== 2'b10) $display("FAIL rel_rr_pick: got %b expected 10", {a_gnt0, a_gnt1});
      else n_pass++;
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_reset_midread;
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h90;
      step();
      step();
      n_total++;
      if ({a_rv0, a_re} !== 2'b11) $display("FAIL rmr_inflight: got %b expected 11", {a_rv0, a_re});
      else n_pass++;
      rst_n = 1'b1;
      #1;
      n_total++;
      if ({a_gnt0, a_rv0, a_re, a_we} !== 4'b0000)
         $display("FAIL rmr_async_clear: got %b expected 0000", {a_gnt0, a_rv0, a_re, a_we});
      else n_pass++;
      step();
      rst_n = 1'b0;
      #1;
      n_total++;
      if (a_gnt0 !== 1'b0) $display("FAIL rmr_post_idle: got %b expected 0", a_gnt0);
      else n_pass++;
      step();
      n_total++;
      if ({a_gnt0, a_re} !== 2'b11) $display("FAIL rmr_regrant: got %b expected 11", {a_gnt0, a_re});
      else n_pass++;
      req0 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read();
      test_burst();
      test_alternate();
      test_midburst();
      test_release();
      test_reset_midread();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
